// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the multi-cycle MIPS memory responder.
// Error-cause codes are kept here so a later Cause register can reuse them.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam int BYTE_LANES = 4;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

    function automatic int idx_width(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/memory_array.sv
// Word-organised single-port storage with byte-lane writes and a registered read port.
// The read register is the responder's RAM_OUT, so it resets to zero and holds between reads.
module memory_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [idx_width(DEPTH_WORDS)-1:0] i_idx,
    input  logic                              i_rd_en,
    input  logic [BYTE_LANES-1:0]             i_wr_be,
    input  logic [DATA_WIDTH-1:0]             i_wr_data,
    output logic [DATA_WIDTH-1:0]             o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (i_wr_be[i]) begin
                r_mem[i_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: request latch, address checks, wait-state counter and response FSM.
//   state   | meaning
//   ST_IDLE | ready to accept MEM_REQ; array indexed by the live Addr
//   ST_WAIT | counting wait states on the latched request
//   ST_RESP | one-cycle MEM_READY (with ADDR_ERR on a bad address); write lands on exit
module memory_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     MEM_REQ,
    input  logic                     MEM_WE,
    input  logic [ADDRESS_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0]    WR_DATA,
    input  logic [BYTE_LANES-1:0]    BYTE_EN,
    output logic [DATA_WIDTH-1:0]    RAM_OUT,
    output logic                     MEM_READY,
    output logic                     ADDR_ERR,
    output logic                     BUSY
);

    localparam int IDX_W = idx_width(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH + 1)'(BYTE_LANES * DEPTH_WORDS);

    mem_state_t             r_state;
    mem_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_we;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [BYTE_LANES-1:0]  r_be;

    logic [1:0]             w_cause;
    logic                   w_accept;
    logic                   w_cur_we;
    logic                   w_cur_err;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_rd_en;
    logic [BYTE_LANES-1:0]  w_wr_be;

    always_comb begin
        w_cause = ERR_NONE;
        if (Addr[1:0] != 2'b00) begin
            w_cause = ERR_MISALIGN;
        end else if ({1'b0, Addr} >= ADDR_LIMIT) begin
            w_cause = ERR_RANGE;
        end
    end

    assign w_accept  = (r_state == ST_IDLE) && MEM_REQ;
    assign w_cur_we  = (r_state == ST_IDLE) ? MEM_WE : r_we;
    assign w_cur_err = (r_state == ST_IDLE) ? (w_cause != ERR_NONE) : r_err;
    assign w_idx     = (r_state == ST_IDLE) ? Addr[IDX_W+1:2] : r_idx;

    // Errors take the same wait path so the control FSM always sees a fixed latency.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (MEM_REQ) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_rd_en = (w_state_nxt == ST_RESP) && !w_cur_we && !w_cur_err;
    assign w_wr_be = ((r_state == ST_RESP) && r_we && !r_err) ? r_be : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx   <= Addr[IDX_W+1:2];
                r_we    <= MEM_WE;
                r_err   <= (w_cause != ERR_NONE);
                r_wdata <= WR_DATA;
                r_be    <= BYTE_EN;
            end
        end
    end

    memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_array (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_idx     (w_idx),
        .i_rd_en   (w_rd_en),
        .i_wr_be   (w_wr_be),
        .i_wr_data (r_wdata),
        .o_rd_data (RAM_OUT)
    );

    assign MEM_READY = (r_state == ST_RESP);
    assign ADDR_ERR  = (r_state == ST_RESP) && r_err;
    assign BUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with two wait states, one with none.
module tb_memory_responder;

    logic        clk;
    logic        rst_b;

    logic        mem_req, mem_we;
    logic [31:0] addr, wr_data;
    logic [3:0]  byte_en;
    logic [31:0] ram_out;
    logic        ready, addr_err, busy;

    logic        mem_req0, mem_we0;
    logic [31:0] addr0, wr_data0;
    logic [3:0]  byte_en0;
    logic [31:0] ram_out0;
    logic        ready0, addr_err0, busy0;

    int n_checks = 0;
    int n_errors = 0;

    memory_responder #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .CLK(clk), .RST(rst_b), .MEM_REQ(mem_req), .MEM_WE(mem_we), .Addr(addr),
        .WR_DATA(wr_data), .BYTE_EN(byte_en), .RAM_OUT(ram_out), .MEM_READY(ready),
        .ADDR_ERR(addr_err), .BUSY(busy)
    );

    memory_responder #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .CLK(clk), .RST(rst_b), .MEM_REQ(mem_req0), .MEM_WE(mem_we0), .Addr(addr0),
        .WR_DATA(wr_data0), .BYTE_EN(byte_en0), .RAM_OUT(ram_out0), .MEM_READY(ready0),
        .ADDR_ERR(addr_err0), .BUSY(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Assumes the accepting posedge is the next one; samples on negedges.
    task automatic await_resp(input bit disturb, input logic orig_we, output int lat,
                              output int n_rdy, output logic err, output logic [31:0] rdata);
        @(posedge clk);
        lat = -1; n_rdy = 0; err = 1'b0; rdata = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                mem_req = 1'b0;
                if (disturb) begin
                    addr    = 32'h30;
                    mem_we  = ~orig_we;
                    wr_data = 32'h0;
                    mem_req = 1'b1;
                end
            end
            if (k == 2) mem_req = 1'b0;
            if (ready) begin
                n_rdy++;
                if (lat < 0) begin
                    lat   = k;
                    err   = addr_err;
                    rdata = ram_out;
                end
            end
        end
    endtask

    task automatic mem_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit disturb, output int lat,
                          output int n_rdy, output logic err, output logic [31:0] rdata);
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; addr = a; wr_data = d; byte_en = be;
        await_resp(disturb, we, lat, n_rdy, err, rdata);
    endtask

    task automatic op0(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_req0 = 1'b1; mem_we0 = we; addr0 = a; wr_data0 = d; byte_en0 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        mem_req0 = 1'b0;
        chk("d0_op_ready", 32'(ready0), 32'd1);
        @(negedge clk);
    endtask

    int          lat, n_rdy, first, second;
    logic        err;
    logic [31:0] rdata;

    initial begin
        rst_b = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; addr = 32'h0; wr_data = 32'h0; byte_en = 4'h0;
        mem_req0 = 1'b0; mem_we0 = 1'b0; addr0 = 32'h0; wr_data0 = 32'h0; byte_en0 = 4'h0;

        // Reset held with a request pending
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ram_out", ram_out, 32'h0);
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        rst_b = 1'b1;
        await_resp(1'b0, 1'b0, lat, n_rdy, err, rdata);
        chk("first_lat", 32'(lat), 32'd3);
        chk("first_nrdy", 32'(n_rdy), 32'd1);

        // Full write, readback, byte-lane merge
        mem_op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, n_rdy, err, rdata);
        chk("wr10_lat", 32'(lat), 32'd3);
        chk("wr10_nrdy", 32'(n_rdy), 32'd1);
        mem_op(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("rd10_lat", 32'(lat), 32'd3);
        chk("rd10_nrdy", 32'(n_rdy), 32'd1);
        chk("rd10_err", 32'(err), 32'd0);
        chk("rd10_data", rdata, 32'hDEADBEEF);
        mem_op(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0, lat, n_rdy, err, rdata);
        chk("wr10b_hold", ram_out, 32'hDEADBEEF);
        mem_op(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("rd10b_data", rdata, 32'hDEADBEAA);

        // Empty byte-enable write still completes and changes nothing
        mem_op(1'b1, 32'h10, 32'h12345678, 4'b0000, 1'b0, lat, n_rdy, err, rdata);
        chk("be0_lat", 32'(lat), 32'd3);
        mem_op(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("be0_data", rdata, 32'hDEADBEAA);

        // Address errors
        mem_op(1'b0, 32'h13, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("mis_lat", 32'(lat), 32'd3);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_hold", rdata, 32'hDEADBEAA);
        mem_op(1'b0, 32'h400, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("rng_lat", 32'(lat), 32'd3);
        chk("rng_err", 32'(err), 32'd1);
        chk("rng_hold", rdata, 32'hDEADBEAA);
        mem_op(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("top_word_err", 32'(err), 32'd0);

        // Input changes while busy are ignored
        mem_op(1'b1, 32'h30, 32'h55667788, 4'hF, 1'b0, lat, n_rdy, err, rdata);
        mem_op(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("rd30_data", rdata, 32'h55667788);
        mem_op(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, lat, n_rdy, err, rdata);
        chk("dist_lat", 32'(lat), 32'd3);
        chk("dist_nrdy", 32'(n_rdy), 32'd1);
        chk("dist_data", rdata, 32'hDEADBEAA);
        mem_op(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("dist_no_wr", rdata, 32'h55667788);

        // Reset during the wait of a write
        mem_op(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, lat, n_rdy, err, rdata);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; addr = 32'h20; wr_data = 32'h0BADBEEF; byte_en = 4'hF;
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst_b = 1'b0;
        n_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ready) n_rdy++;
        end
        chk("abort_nrdy", 32'(n_rdy), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ram_out", ram_out, 32'h0);
        rst_b = 1'b1;
        mem_op(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, lat, n_rdy, err, rdata);
        chk("abort_rd20", rdata, 32'hCAFEF00D);

        // Zero wait states: back-to-back reads
        op0(1'b1, 32'h0, 32'h11111111);
        op0(1'b1, 32'h4, 32'h22222222);
        @(negedge clk);
        mem_req0 = 1'b1; mem_we0 = 1'b0; addr0 = 32'h0;
        first = -1; second = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ready0) begin
                if (first < 0) begin
                    first = k;
                    chk("b2b_rd0", ram_out0, 32'h11111111);
                    addr0 = 32'h4;
                end else if (second < 0) begin
                    second = k;
                    chk("b2b_rd4", ram_out0, 32'h22222222);
                    mem_req0 = 1'b0;
                end
            end
        end
        mem_req0 = 1'b0;
        chk("b2b_first", 32'(first), 32'd1);
        chk("b2b_second", 32'(second), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
